dsc_mult_sched: RTL and testbench

Sequencing controller for one deterministic stochastic computing (DSC) multiply. It accepts two unsigned binary operands and drives counter-based stream generation across `LANES` parallel bit-lanes. Operand A's stream uses the rotating-counter method; operand B's stream uses clock-division. Each cycle it ANDs the lanes, popcounts them into an accumulator, and returns the exact binary product through a valid/ready handshake. It sits between the binary operand source and the downstream consumer, replacing hand-sequenced SNG counter / parallel accumulator pairs.

---
 rtl/dsc_mult_sched.sv | 137 +++++++++++++
 tb/tb_dsc_mult_sched.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/dsc_mult_sched.sv
// Deterministic stochastic-computing multiply sequencer: rotating-counter stream for A,
// clock-division stream for B, LANES bits ANDed and popcounted into an exact product.

module dsc_mult_lane #(
  parameter int WIDTH = 4,
  parameter int K     = 0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] i,
  input  logic             sb,
  output logic             sbit
);
  logic [WIDTH:0] pos;

  // i+K is compared one bit wider so the last lanes of a row never wrap.
  assign pos  = {1'b0, i} + (WIDTH+1)'(K);
  assign sbit = ({1'b0, a} > pos) & sb;
endmodule

module dsc_mult_sched #(
  parameter int WIDTH = 4,
  parameter int LANES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a_in,
  input  logic [WIDTH-1:0]     b_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   result,
  output logic                 lane_valid,
  output logic [LANES-1:0]     lane_bits
);
  localparam int PW = $clog2(LANES) + 1;
  localparam logic [WIDTH-1:0] I_LAST = WIDTH'((1 << WIDTH) - LANES);
  localparam logic [WIDTH-1:0] I_STEP = WIDTH'(LANES);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } op_t;

  state_t             state;
  op_t                op_q;
  logic [WIDTH-1:0]   i_q, j_q;
  logic [2*WIDTH-1:0] acc;
  logic [LANES-1:0]   lane_raw;
  logic [PW-1:0]      pop;
  logic               sb, row_end, last;

  assign sb      = op_q.b > j_q;
  assign row_end = i_q == I_LAST;
  assign last    = row_end && (j_q == op_q.b - 1'b1);

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    dsc_mult_lane #(.WIDTH(WIDTH), .K(k)) u_lane (
      .a    (op_q.a),
      .i    (i_q),
      .sb   (sb),
      .sbit (lane_raw[k])
    );
  end

  assign lane_bits = (state == RUN) ? lane_raw : '0;

  always_comb begin
    pop = '0;
    for (int k = 0; k < LANES; k++) pop = pop + PW'(lane_bits[k]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      lane_valid <= 1'b0;
      op_q       <= '0;
      i_q        <= '0;
      j_q        <= '0;
      acc        <= '0;
      result     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            op_q     <= '{a: a_in, b: b_in};
            i_q      <= '0;
            j_q      <= '0;
            acc      <= '0;
            in_ready <= 1'b0;
            if (b_in == '0) begin
              state     <= DONE;
              result    <= '0;
              out_valid <= 1'b1;
            end else begin
              state      <= RUN;
              lane_valid <= 1'b1;
            end
          end
        end
        RUN: begin
          acc <= acc + (2*WIDTH)'(pop);
          if (row_end) begin
            i_q <= '0;
            j_q <= j_q + 1'b1;
          end else begin
            i_q <= i_q + I_STEP;
          end
          // Rows j >= b contribute nothing, so the run ends on the last useful row.
          if (last) begin
            state      <= DONE;
            lane_valid <= 1'b0;
            out_valid  <= 1'b1;
            result     <= acc + (2*WIDTH)'(pop);
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          in_ready   <= 1'b1;
          out_valid  <= 1'b0;
          lane_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_dsc_mult_sched.sv
// Directed checks of dsc_mult_sched: latency, products, backpressure, reset, and a
// small per-LANES sweep with a*b and b*16/LANES as the expected result and run length.

module tb_dsc_mult_sched;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, in_valid, in_ready, out_valid, out_ready, lane_valid;
  logic [3:0] a_in, b_in, lane_bits;
  logic [7:0] result;

  logic       v3_in_valid, v3_in_ready, v3_out_valid, v3_lane_valid;
  logic [2:0] v3_a, v3_b;
  logic [5:0] v3_result;
  logic [0:0] v3_lane_bits;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   sw_fin  = 0;
  logic sw_go   = 1'b0;

  dsc_mult_sched #(.WIDTH(4), .LANES(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .lane_valid(lane_valid), .lane_bits(lane_bits)
  );

  dsc_mult_sched #(.WIDTH(3), .LANES(1)) u_w3 (
    .clk(clk), .rst(rst), .in_valid(v3_in_valid), .in_ready(v3_in_ready),
    .a_in(v3_a), .b_in(v3_b), .out_valid(v3_out_valid), .out_ready(1'b1),
    .result(v3_result), .lane_valid(v3_lane_valid), .lane_bits(v3_lane_bits)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One transaction on the main instance with out_ready held high.
  task automatic do_op(input logic [3:0] a, input logic [3:0] b,
                       input int exp_n, input logic [7:0] exp_res);
    int c, nl, ps;
    bit seen;
    c = 0;
    while (!in_ready && c < 500) begin @(negedge clk); c++; end
    chk("rdy_before", in_ready, 1);
    a_in = a; b_in = b; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    nl = 0; ps = 0; seen = 0;
    for (c = 1; c <= 400 && !seen; c++) begin
      @(negedge clk);
      if (c == 1) chk("in_ready_fall", in_ready, 0);
      if (lane_valid) begin nl++; ps += $countones(lane_bits); end
      if (out_valid) begin
        seen = 1;
        chk("out_lat", c, exp_n + 1);
        chk("result", result, exp_res);
      end
    end
    chk("out_seen", seen, 1);
    chk("n_run", nl, exp_n);
    chk("popsum", ps, exp_res);
    @(negedge clk);
    chk("back_idle", in_ready, 1);
    chk("ov_drop", out_valid, 0);
    chk("res_hold", result, exp_res);
  endtask

  for (genvar g = 0; g < 5; g++) begin : g_sw
    localparam int L = 1 << g;
    logic         iv, ir, ov, lv;
    logic [3:0]   sa, sb;
    logic [7:0]   res;
    logic [L-1:0] lb;

    dsc_mult_sched #(.WIDTH(4), .LANES(L)) u_sw (
      .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir),
      .a_in(sa), .b_in(sb), .out_valid(ov), .out_ready(1'b1),
      .result(res), .lane_valid(lv), .lane_bits(lb)
    );

    initial begin
      iv = 1'b0; sa = '0; sb = '0;
      wait (sw_go);
      @(negedge clk);
      for (int p = 0; p < 20; p++) begin
        logic [3:0] a, b;
        int n, c;
        bit seen;
        case (p)
          0:       begin a = 4'd15; b = 4'd15; end
          1:       begin a = 4'd0;  b = 4'd15; end
          2:       begin a = 4'd9;  b = 4'd0;  end
          3:       begin a = 4'd1;  b = 4'd1;  end
          default: begin a = 4'($urandom_range(15)); b = 4'($urandom_range(15)); end
        endcase
        chk($sformatf("sw%0d_rdy", L), ir, 1);
        sa = a; sb = b; iv = 1'b1;
        @(posedge clk); #1 iv = 1'b0;
        n = 0; seen = 0;
        for (c = 1; c <= 300 && !seen; c++) begin
          @(negedge clk);
          if (lv) n++;
          if (ov) seen = 1;
        end
        chk($sformatf("sw%0d_seen", L), seen, 1);
        chk($sformatf("sw%0d_n a=%0d b=%0d", L, a, b), n, int'(b) * 16 / L);
        chk($sformatf("sw%0d_res a=%0d b=%0d", L, a, b), res, int'(a) * int'(b));
        @(negedge clk);
      end
      sw_fin++;
    end
  end

  initial begin
    int c, n;
    bit seen;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a_in = '0; b_in = '0;
    v3_in_valid = 1'b0; v3_a = '0; v3_b = '0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_lane_valid", lane_valid, 0);
    chk("rst_lane_bits", lane_bits, 0);
    chk("rst_result", result, 0);
    rst = 1'b0;
    @(negedge clk);

    do_op(4'd5,  4'd3,  12, 8'd15);
    do_op(4'd0,  4'd9,  36, 8'd0);
    do_op(4'd15, 4'd15, 60, 8'd225);
    do_op(4'd7,  4'd0,  0,  8'd0);

    // Backpressure: result held, no capture while DONE stalls.
    out_ready = 1'b0;
    a_in = 4'd3; b_in = 4'd2; in_valid = 1'b1;
    @(posedge clk); #1 a_in = 4'd11; b_in = 4'd13;
    seen = 0;
    for (c = 0; c < 50 && !seen; c++) begin @(negedge clk); seen = out_valid; end
    chk("bp_seen", seen, 1);
    for (int k = 0; k < 10; k++) begin
      chk("bp_result", result, 6);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_idle", in_ready, 1);
    chk("bp_release_ov", out_valid, 0);
    chk("bp_release_res", result, 6);

    // Reset in the middle of a run.
    a_in = 4'd9; b_in = 4'd6; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_lane_valid", lane_valid, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_result", result, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_lane_valid", lane_valid, 0);
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 30; k++) begin @(negedge clk); if (out_valid) seen = 1; end
    chk("mid_rst_no_ov", seen, 0);
    do_op(4'd2, 4'd2, 8, 8'd4);

    // WIDTH=3, LANES=1.
    v3_a = 3'd6; v3_b = 3'd5; v3_in_valid = 1'b1;
    @(posedge clk); #1 v3_in_valid = 1'b0;
    n = 0; seen = 0;
    for (c = 1; c <= 200 && !seen; c++) begin
      @(negedge clk);
      if (v3_lane_valid) n++;
      if (v3_out_valid) begin seen = 1; chk("w3_lat", c, 41); end
    end
    chk("w3_seen", seen, 1);
    chk("w3_n", n, 40);
    chk("w3_result", v3_result, 30);

    sw_go = 1'b1;
    c = 0;
    while (sw_fin < 5 && c < 60000) begin @(negedge clk); c++; end
    chk("sweep_done", sw_fin, 5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
